mem_arbiter_ctrl: RTL
=====================

Name: mem_arbiter_ctrl

Overview:
Two-requester arbiter and sequencer for the small word-addressed scratch memory (DEPTH = 2**ADDR_W words of DATA_W bits) used on the board datapath. The block owns the storage array. It serialises read/write requests from port A (switch/user side) and port B (auto/scan side) with round-robin fairness. After reset it runs a clear sweep that writes zero to every word. Its outputs feed the LED/7-segment display logic.

Parameters:
ADDR_W, 2, address width; DEPTH = 2**ADDR_W
DATA_W, 4, data word width

Ports:
clk_2  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
req_a  in  1  port A request; held with we_a/addr_a/wdata_a stable until gnt_a seen
we_a  in  1  port A: 1 = write, 0 = read
addr_a  in  ADDR_W  port A address
wdata_a  in  DATA_W  port A write data
gnt_a  out  1  port A grant, one-cycle pulse
rvalid_a  out  1  port A read data valid, one-cycle pulse
rdata_a  out  DATA_W  port A read data, held until next A read completes
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as port A, for port B
busy  out  1  1 while in CLEAR or ACCESS
last_grant  out  1  0 = A was last granted, 1 = B was last granted

Behaviour:
- Reset is synchronous, active-high, on clock clk_2, and has priority over everything.
- While reset is high: state=CLEAR, clr_addr=0, gnt_*=0, rvalid_*=0, rdata_*=0, last_grant=1 (so A wins the first tie).
- busy = (state != IDLE), combinational from state.
- States: CLEAR, IDLE, ACCESS.
- CLEAR:
  - Each cycle writes 0 to mem[clr_addr], then clr_addr increments.
  - After writing DEPTH-1, go to IDLE. That is exactly DEPTH cycles after reset deasserts.
  - Requests are ignored here; requesters keep req high and are served later.
- IDLE:
  - No req: stay in IDLE.
  - Only one req: that port wins.
  - Both req: the port != last_grant wins.
  - On the edge: capture winner's we/addr/wdata, set owner, go to ACCESS, set gnt_owner=1 for the following cycle, update last_grant=owner.
- ACCESS (one cycle, gnt_owner=1):
  - Write: mem[addr] <= wdata commits on the closing edge.
  - Read: rdata_owner <= mem[addr] on the closing edge, and rvalid_owner=1 for the next cycle.
  - Always return to IDLE.
- Timing: req sampled in cycle n -> gnt in n+1 -> write committed / rvalid with data in n+2.
  - Peak throughput is one access per 2 cycles.
  - A port holding req continuously gets served alternately with the other port.
- Requester must drop req in the cycle after gnt. If req is still high in IDLE, it is treated as a new request.
- rdata of the non-owner port is unchanged.
- Reset mid-ACCESS: the access is aborted and no write commits on that edge; rvalid stays 0 and the FSM restarts CLEAR.
- Reset mid-CLEAR: the sweep restarts at address 0.
- Address wrap: clr_addr is ADDR_W bits and wraps naturally. The terminal condition is clr_addr == DEPTH-1.
- Read-after-write to the same address from different ports returns the new data, because accesses are serialised.
- Memory contents are not reset directly; they are cleared only by the sweep.

Optional Feature:
MEM_CLEAR_EN
- Defined: behaviour as above. After reset deasserts, busy=1 for DEPTH cycles while the clear sweep runs.
- Undefined: there is no CLEAR state and no clr_addr. Reset sends the FSM directly to IDLE, so busy=0 during and after reset. Memory contents are retained across reset and are X after power-up. The first request is granted in the cycle after it is sampled.

Test Plan:
- Reset 3 cycles then release (MEM_CLEAR_EN) -> busy=1 for exactly 4 cycles then 0; A reads addr 0..3 -> each rvalid_a with rdata_a=0x0.
- A write addr 2 data 0x9, then B read addr 2 -> gnt_a pulse, next access gnt_b, rvalid_b with rdata_b=0x9; rdata_a unchanged at 0.
- req_a and req_b both held high from IDLE after reset -> grants alternate A,B,A,B; last_grant toggles 0,1,0,1; never two gnts in the same cycle.
- A write addr 1 data 0xF, reset asserted during the gnt_a cycle -> after clear, A read addr 1 returns 0x0, rvalid_a never pulsed for the aborted op.
- A read addr 3 (holding 0x5), then B writes addr 3 = 0xA -> rdata_a stays 0x5 through B's access; a new A read returns 0xA.
- MEM_CLEAR_EN undefined: release reset with req_a high -> busy=0 immediately, gnt_a in the 2nd cycle after reset release, written data survives a later reset pulse.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - two-port round-robin arbiter/sequencer owning a small scratch memory
//
// Optional feature macro: MEM_CLEAR_EN (post-reset clear sweep of every word).
//
// Ports:
//   clk_2, reset                  clock and synchronous active-high reset
//   req_a/we_a/addr_a/wdata_a     port A request (held until gnt_a)
//   gnt_a, rvalid_a, rdata_a      port A grant pulse, read-valid pulse, held read data
//   req_b/.../rdata_b             same for port B
//   busy                          high whenever the sequencer is not idle
//   last_grant                    0 = A granted last, 1 = B granted last
module mem_arbiter_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic              last_grant
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef MEM_CLEAR_EN
    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS} state_t;
    localparam state_t RESET_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_addr;
`else
    typedef enum logic [1:0] {IDLE, ACCESS} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              owner;      // 0 = A, 1 = B for the access in flight
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic take;    // a request is accepted on this edge
    logic win_b;   // winner of this cycle's arbitration

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        take       = 1'b0;
        win_b      = 1'b0;
        case (state)
`ifdef MEM_CLEAR_EN
            CLEAR: begin
                if (clr_addr == {ADDR_W{1'b1}}) begin
                    next_state = IDLE;
                end
            end
`endif
            IDLE: begin
                if (req_a || req_b) begin
                    take       = 1'b1;
                    next_state = ACCESS;
                    // On a tie the port that was not granted last wins.
                    win_b      = req_b && (!req_a || !last_grant);
                end
            end
            ACCESS: next_state = IDLE;
            default: next_state = RESET_STATE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign gnt_a = (state == ACCESS) && !owner;
    assign gnt_b = (state == ACCESS) && owner;

    // Request capture; held for the single ACCESS cycle.
    always_ff @(posedge clk_2) begin
        if (take) begin
            cap_we    <= win_b ? we_b    : we_a;
            cap_addr  <= win_b ? addr_b  : addr_a;
            cap_wdata <= win_b ? wdata_b : wdata_a;
        end
    end

    // Storage is never reset directly; reset only suppresses writes.
    always_ff @(posedge clk_2) begin
        if (!reset) begin
`ifdef MEM_CLEAR_EN
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end
`endif
            if (state == ACCESS && cap_we) begin
                mem[cap_addr] <= cap_wdata;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rvalid_a   <= 1'b0;
            rvalid_b   <= 1'b0;
            rdata_a    <= '0;
            rdata_b    <= '0;
`ifdef MEM_CLEAR_EN
            clr_addr   <= '0;
`endif
        end else begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
`ifdef MEM_CLEAR_EN
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
`endif
            if (take) begin
                owner      <= win_b;
                last_grant <= win_b;
            end
            if (state == ACCESS && !cap_we) begin
                if (owner) begin
                    rdata_b  <= mem[cap_addr];
                    rvalid_b <= 1'b1;
                end else begin
                    rdata_a  <= mem[cap_addr];
                    rvalid_a <= 1'b1;
                end
            end
        end
    end

endmodule
